// File: rtl/tds_rx_align_ctrl_if.sv
// Signal bundle between the TDS GTP receive lane and its alignment controller.
// The controller takes the slave side; the GT wrapper or a testbench takes the master side.
interface tds_rx_align_ctrl_if;
  logic        rx_fsm_reset_done;
  logic [19:0] rx_data;
  logic        rx_err_in;
  logic        relock_req;
  logic        rxslide;
  logic        gt_soft_reset;
  logic        data_valid;
  logic        link_up;
  logic [2:0]  state;
  logic [5:0]  slide_count;
  logic [7:0]  reset_count;

  modport master (
    output rx_fsm_reset_done, rx_data, rx_err_in, relock_req,
    input  rxslide, gt_soft_reset, data_valid, link_up, state, slide_count, reset_count
  );

  modport slave (
    input  rx_fsm_reset_done, rx_data, rx_err_in, relock_req,
    output rxslide, gt_soft_reset, data_valid, link_up, state, slide_count, reset_count
  );
endinterface

// File: rtl/tds_rx_align_ctrl.sv
// Bring-up controller for the 20-bit raw GTP RX lane: RXSLIDE word alignment,
// lock confirmation, data-valid drive, error-window monitoring and GT soft reset.
module tds_rx_align_ctrl #(
  parameter logic [19:0] ALIGN_PATTERN  = 20'hFC0F0,
  parameter int unsigned LOCK_COUNT     = 64,
  parameter int unsigned SLIDE_WAIT_CYC = 32,
  parameter int unsigned MAX_SLIDES     = 40,
  parameter int unsigned ERR_LIMIT      = 4,
  parameter int unsigned ERR_WINDOW     = 4096,
  parameter int unsigned RESET_PULSE    = 16
) (
  input  logic               data_clk,
  input  logic               rst_n,
  tds_rx_align_ctrl_if.slave bus
);
  localparam logic [2:0] WAIT_DONE  = 3'd0;
  localparam logic [2:0] SEARCH     = 3'd1;
  localparam logic [2:0] SLIDE_WAIT = 3'd2;
  localparam logic [2:0] VERIFY     = 3'd3;
  localparam logic [2:0] LOCKED     = 3'd4;
  localparam logic [2:0] RESET_GT   = 3'd5;

  localparam int unsigned      WIN_W      = (ERR_WINDOW > 2) ? $clog2(ERR_WINDOW) : 1;
  localparam logic [WIN_W-1:0] WIN_LAST   = WIN_W'(ERR_WINDOW - 1);
  localparam logic [15:0]      SLIDE_LAST = 16'(SLIDE_WAIT_CYC - 1);
  localparam logic [15:0]      PULSE_LAST = 16'(RESET_PULSE - 1);
  localparam logic [5:0]       SLIDE_MAX  = 6'(MAX_SLIDES);
  localparam logic [7:0]       GOOD_LOCK  = 8'(LOCK_COUNT);
  localparam logic [7:0]       ERR_MAX    = 8'(ERR_LIMIT);

  logic             done_s1_q, done_sync_q, done_prev_q, relock_prev_q;
  logic [2:0]       state_q, state_d;
  logic [15:0]      tmr_q, tmr_d;
  logic [5:0]       slide_count_q, slide_d;
  logic [7:0]       good_cnt_q, good_d;
  logic [7:0]       err_cnt_q, err_d, err_inc;
  logic [WIN_W-1:0] win_q, win_d;
  logic             need_low_q, need_low_d;
  logic [7:0]       reset_count_q, reset_count_d;
  logic             rxslide_q, rxslide_d;
  logic             gt_soft_reset_q, gt_soft_reset_d;
  logic             data_valid_q, link_up_q, link_up_d;
  logic             done_fall, relock_rise, match;

  always_comb begin
    done_fall     = done_prev_q & ~done_sync_q;
    relock_rise   = bus.relock_req & ~relock_prev_q;
    match         = (bus.rx_data == ALIGN_PATTERN);
    err_inc       = (err_cnt_q != 8'hFF) ? err_cnt_q + 8'd1 : err_cnt_q;
    state_d       = state_q;
    tmr_d         = tmr_q + 16'd1;
    slide_d       = slide_count_q;
    good_d        = good_cnt_q;
    err_d         = err_cnt_q;
    win_d         = '0;
    need_low_d    = need_low_q & done_sync_q;
    reset_count_d = reset_count_q;

    if (done_fall && state_q != RESET_GT && state_q != WAIT_DONE) begin
      state_d = WAIT_DONE;
    end else if (relock_rise && state_q != RESET_GT) begin
      state_d = RESET_GT;
    end else begin
      case (state_q)
        WAIT_DONE: if (done_sync_q && !need_low_q) state_d = SEARCH;
        SEARCH: begin
          if (match) begin
            state_d = VERIFY;
            good_d  = 8'd1;
          end else if (slide_count_q < SLIDE_MAX) begin
            state_d = SLIDE_WAIT;
            slide_d = slide_count_q + 6'd1;
          end else begin
            state_d = RESET_GT;
          end
        end
        SLIDE_WAIT: if (tmr_q == SLIDE_LAST) state_d = SEARCH;
        VERIFY: begin
          if (match) begin
            good_d = good_cnt_q + 8'd1;
            if (good_d == GOOD_LOCK) state_d = LOCKED;
          end else begin
            state_d = SEARCH;
            good_d  = '0;
          end
        end
        LOCKED: begin
          // An error in the wrap cycle is the first error of the new window.
          win_d = (win_q == WIN_LAST) ? '0 : win_q + WIN_W'(1);
          if (win_q == WIN_LAST) err_d = {7'd0, bus.rx_err_in};
          else if (bus.rx_err_in) err_d = err_inc;
          if (bus.rx_err_in && err_d >= ERR_MAX) state_d = RESET_GT;
        end
        RESET_GT: if (tmr_q == PULSE_LAST) state_d = WAIT_DONE;
        default: state_d = WAIT_DONE;
      endcase
    end

    if (state_d != state_q) tmr_d = '0;
    // A done level left over from before the GT reset must not restart the search.
    if (state_d == RESET_GT && state_q != RESET_GT) begin
      need_low_d = 1'b1;
      if (reset_count_q != 8'hFF) reset_count_d = reset_count_q + 8'd1;
    end
    if (state_d == WAIT_DONE) begin
      slide_d = '0;
      good_d  = '0;
      err_d   = '0;
    end
    rxslide_d       = (state_q == SEARCH) && (state_d == SLIDE_WAIT);
    gt_soft_reset_d = (state_d == RESET_GT);
    link_up_d       = (state_d == LOCKED);
  end

  always_ff @(posedge data_clk or negedge rst_n) begin
    if (!rst_n) begin
      done_s1_q       <= 1'b0;
      done_sync_q     <= 1'b0;
      done_prev_q     <= 1'b0;
      relock_prev_q   <= 1'b0;
      state_q         <= WAIT_DONE;
      tmr_q           <= '0;
      slide_count_q   <= '0;
      good_cnt_q      <= '0;
      err_cnt_q       <= '0;
      win_q           <= '0;
      need_low_q      <= 1'b0;
      reset_count_q   <= '0;
      rxslide_q       <= 1'b0;
      gt_soft_reset_q <= 1'b0;
      data_valid_q    <= 1'b0;
      link_up_q       <= 1'b0;
    end else begin
      done_s1_q       <= bus.rx_fsm_reset_done;
      done_sync_q     <= done_s1_q;
      done_prev_q     <= done_sync_q;
      relock_prev_q   <= bus.relock_req;
      state_q         <= state_d;
      tmr_q           <= tmr_d;
      slide_count_q   <= slide_d;
      good_cnt_q      <= good_d;
      err_cnt_q       <= err_d;
      win_q           <= win_d;
      need_low_q      <= need_low_d;
      reset_count_q   <= reset_count_d;
      rxslide_q       <= rxslide_d;
      gt_soft_reset_q <= gt_soft_reset_d;
      data_valid_q    <= link_up_d;
      link_up_q       <= link_up_d;
    end
  end

  assign bus.rxslide       = rxslide_q;
  assign bus.gt_soft_reset = gt_soft_reset_q;
  assign bus.data_valid    = data_valid_q;
  assign bus.link_up       = link_up_q;
  assign bus.state         = state_q;
  assign bus.slide_count   = slide_count_q;
  assign bus.reset_count   = reset_count_q;
endmodule
